// File: rtl/wishbone_master_if_pkg.sv
// Shared widths, FSM encodings and request payload for the Wishbone classic initiator.
package wishbone_master_if_pkg;

    localparam int unsigned WB_ADDR_W = 32;
    localparam int unsigned WB_DATA_W = 32;
    localparam int unsigned WB_SEL_W  = 4;
    localparam int unsigned STALL_W   = 6;

    localparam logic [1:0] WB_IDLE           = 2'd0;
    localparam logic [1:0] WB_BUSY           = 2'd1;
    localparam logic [1:0] WB_WAIT_FOR_STALL = 2'd2;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
        logic                 we;
        logic [WB_SEL_W-1:0]  sel;
    } wb_req_t;

    // Counter width able to hold 0 .. n-1.
    function automatic int unsigned wd_cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Counts BUSY cycles without acknowledge and flags the cycle on which the transfer must be aborted.
module wb_watchdog
    import wishbone_master_if_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic busy,
    input  logic ack,
    output logic timeout_c
);

    localparam int unsigned CNT_W = wd_cnt_width(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;

    // Fires on the TIMEOUT_CYCLES-th unacknowledged BUSY cycle.
    assign timeout_c = busy && !ack && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (busy && !ack && !timeout_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= '0;
        end
    end

endmodule

// File: rtl/wishbone_master_if.sv
// Wishbone classic initiator for one CPU memory port: single cyc/stb transfer per request, stalls the pipeline until ack.
// Optional bus timeout abort enabled by defining WB_TIMEOUT_EN (adds the TIMEOUT_CYCLES parameter).
module wishbone_master_if
    import wishbone_master_if_pkg::*;
`ifdef WB_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [STALL_W-1:0]   stall_i,
    input  logic                 flush_i,
    input  logic                 cpu_ce_i,
    input  logic                 cpu_we_i,
    input  logic [WB_ADDR_W-1:0] cpu_addr_i,
    input  logic [WB_SEL_W-1:0]  cpu_sel_i,
    input  logic [WB_DATA_W-1:0] cpu_data_i,
    output logic [WB_DATA_W-1:0] cpu_data_o,
    output logic                 stall_req_o,
    output logic                 bus_err_o,
    output logic [WB_ADDR_W-1:0] wishbone_addr_o,
    output logic [WB_DATA_W-1:0] wishbone_data_o,
    output logic                 wishbone_we_o,
    output logic [WB_SEL_W-1:0]  wishbone_sel_o,
    output logic                 wishbone_stb_o,
    output logic                 wishbone_cyc_o,
    input  logic [WB_DATA_W-1:0] wishbone_data_i,
    input  logic                 wishbone_ack_i
);

    logic [1:0]           state_q, state_d;
    wb_req_t              req_q, req_d;
    logic                 act_q, act_d;
    logic [WB_DATA_W-1:0] rd_buf_q, rd_buf_d;
    logic                 bus_err_q, bus_err_d;
    logic                 timeout_c;
    logic                 stalled_c;

    assign stalled_c = |stall_i;

`ifdef WB_TIMEOUT_EN
    wb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wb_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .busy      (state_q == WB_BUSY),
        .ack       (wishbone_ack_i),
        .timeout_c (timeout_c)
    );
`else
    assign timeout_c = 1'b0;
`endif

    // State and registered bus outputs; async reset drops cyc/stb immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WB_IDLE;
            req_q     <= '0;
            act_q     <= 1'b0;
            rd_buf_q  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            act_q     <= act_d;
            rd_buf_q  <= rd_buf_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Next state and next register values; ack takes priority over flush and timeout.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        act_d     = act_q;
        rd_buf_d  = rd_buf_q;
        bus_err_d = 1'b0;
        case (state_q)
            WB_IDLE: begin
                if (cpu_ce_i && !flush_i) begin
                    req_d.addr = cpu_addr_i;
                    req_d.data = cpu_data_i;
                    req_d.we   = cpu_we_i;
                    req_d.sel  = cpu_sel_i;
                    act_d      = 1'b1;
                    state_d    = WB_BUSY;
                end
            end
            WB_BUSY: begin
                if (wishbone_ack_i) begin
                    req_d    = '0;
                    act_d    = 1'b0;
                    rd_buf_d = req_q.we ? '0 : wishbone_data_i;
                    state_d  = stalled_c ? WB_WAIT_FOR_STALL : WB_IDLE;
                end else if (flush_i) begin
                    req_d    = '0;
                    act_d    = 1'b0;
                    rd_buf_d = '0;
                    state_d  = WB_IDLE;
                end else if (timeout_c) begin
                    req_d     = '0;
                    act_d     = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = WB_IDLE;
                end
            end
            WB_WAIT_FOR_STALL: begin
                if (!stalled_c || flush_i) begin
                    state_d = WB_IDLE;
                end
            end
            default: begin
                state_d = WB_IDLE;
            end
        endcase
    end

    // Combinational CPU-side handshake; store acks return zero data.
    always_comb begin
        stall_req_o = 1'b0;
        cpu_data_o  = '0;
        case (state_q)
            WB_IDLE: begin
                stall_req_o = cpu_ce_i && !flush_i;
            end
            WB_BUSY: begin
                stall_req_o = !wishbone_ack_i && !timeout_c;
                if (wishbone_ack_i && !req_q.we) begin
                    cpu_data_o = wishbone_data_i;
                end
            end
            WB_WAIT_FOR_STALL: begin
                cpu_data_o = rd_buf_q;
            end
            default: begin
                stall_req_o = 1'b0;
            end
        endcase
    end

    assign wishbone_addr_o = req_q.addr;
    assign wishbone_data_o = req_q.data;
    assign wishbone_we_o   = req_q.we;
    assign wishbone_sel_o  = req_q.sel;
    assign wishbone_stb_o  = act_q;
    assign wishbone_cyc_o  = act_q;
    assign bus_err_o       = bus_err_q;

endmodule
